// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with a registered one-hot grant and an
// optional hold limit; every release leaves one idle cycle before the next grant.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state_q;
    logic [2:0]    ptr_q;
    logic [7:0]    gnt_q;
    logic          gnt_valid_q;
    logic          timeout_q;
    logic [CW-1:0] hold_q;

    logic [14:0] req_dbl;
    logic [7:0]  req_rot;
    logic [2:0]  off_d;
    logic [2:0]  win_d;
    logic        hold_at_lim;

    // Rotate so the pointer position is bit 0, then take the lowest set bit.
    always_comb begin
        req_dbl = {req[6:0], req};
        req_rot = req_dbl[ptr_q +: 8];
        off_d   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) off_d = 3'(i);
        end
        win_d       = ptr_q + off_d;
        hold_at_lim = (MAX_HOLD != 0) && (hold_q == HOLD_LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            gnt_q       <= 8'h00;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (|req) begin
                        gnt_q       <= 8'b1 << win_d;
                        gnt_valid_q <= 1'b1;
                        state_q     <= GRANT;
                        hold_q      <= CW'(1);
                        ptr_q       <= win_d + 3'd1;
                    end
                end
                GRANT: begin
                    if (~|(gnt_q & req)) begin
                        gnt_q       <= 8'h00;
                        gnt_valid_q <= 1'b0;
                        timeout_q   <= 1'b0;
                        hold_q      <= '0;
                        state_q     <= IDLE;
                    end else if (hold_at_lim) begin
                        gnt_q       <= 8'h00;
                        gnt_valid_q <= 1'b0;
                        timeout_q   <= 1'b1;
                        hold_q      <= '0;
                        state_q     <= IDLE;
                    end else if (hold_q != '1) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    gnt_q       <= 8'h00;
                    gnt_valid_q <= 1'b0;
                    timeout_q   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: default, MAX_HOLD=4 and MAX_HOLD=0 instances.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_m;
    logic [7:0] req_h;
    logic [7:0] gnt_m, gnt_4, gnt_0;
    logic       gv_m, gv_4, gv_0;
    logic       to_m, to_4, to_0;

    int total;
    int bad;

    rr_arbiter8 dut (
        .clk(clk), .rst_n(rst_n), .req(req_m),
        .gnt(gnt_m), .gnt_valid(gv_m), .timeout(to_m)
    );

    rr_arbiter8 #(.MAX_HOLD(4)) dut_h4 (
        .clk(clk), .rst_n(rst_n), .req(req_h),
        .gnt(gnt_4), .gnt_valid(gv_4), .timeout(to_4)
    );

    rr_arbiter8 #(.MAX_HOLD(0)) dut_h0 (
        .clk(clk), .rst_n(rst_n), .req(req_h),
        .gnt(gnt_0), .gnt_valid(gv_0), .timeout(to_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] enc(input logic [7:0] v);
        enc = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) enc = 3'(i);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        req_m = 8'h00;
        req_h = 8'h00;
        repeat (2) @(negedge clk);
        total++;
        if (gnt_m !== 8'h00 || gv_m !== 1'b0 || to_m !== 1'b0) begin
            bad++;
            $display("FAIL reset_init: gnt=%h valid=%b timeout=%b want 00/0/0", gnt_m, gv_m, to_m);
        end
        rst_n = 1'b1;
        req_m = 8'h08;
        @(negedge clk);
        total++;
        if (gnt_m !== 8'h08 || gv_m !== 1'b1) begin
            bad++;
            $display("FAIL grant_before_reset: gnt=%h valid=%b want 08/1", gnt_m, gv_m);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (gnt_m !== 8'h00 || gv_m !== 1'b0 || to_m !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: gnt=%h valid=%b timeout=%b want 00/0/0", gnt_m, gv_m, to_m);
        end
        req_m = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (gnt_m !== 8'h00 || gv_m !== 1'b0) begin
                bad++;
                $display("FAIL idle_cycle%0d: gnt=%h valid=%b want 00/0", i, gnt_m, gv_m);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp;
        req_m = 8'hFF;
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            exp = 8'h01 << (k % 8);
            total++;
            if (gnt_m !== exp || gv_m !== 1'b1) begin
                bad++;
                $display("FAIL rr_grant%0d: gnt=%h valid=%b want %h/1", k, gnt_m, gv_m, exp);
            end
            repeat (2) @(negedge clk);
            total++;
            if (gnt_m !== exp) begin
                bad++;
                $display("FAIL rr_hold%0d: gnt=%h want %h", k, gnt_m, exp);
            end
            req_m = 8'hFF & ~exp;
            @(negedge clk);
            total++;
            if (gnt_m !== 8'h00 || gv_m !== 1'b0 || to_m !== 1'b0) begin
                bad++;
                $display("FAIL rr_bubble%0d: gnt=%h valid=%b timeout=%b want 00/0/0", k, gnt_m, gv_m, to_m);
            end
            req_m = (k == 8) ? 8'h00 : 8'hFF;
            @(negedge clk);
        end
    endtask

    task automatic test_skip_wrap();
        req_m = 8'h40;
        @(negedge clk);
        total++;
        if (gnt_m !== 8'h40) begin
            bad++;
            $display("FAIL skip_g6: gnt=%h want 40", gnt_m);
        end
        req_m = 8'h05;
        @(negedge clk);
        total++;
        if (gnt_m !== 8'h00) begin
            bad++;
            $display("FAIL skip_bubble: gnt=%h want 00", gnt_m);
        end
        @(negedge clk);
        total++;
        if (gnt_m !== 8'h01) begin
            bad++;
            $display("FAIL skip_wrap: gnt=%h want 01", gnt_m);
        end
        req_m = 8'h04;
        repeat (2) @(negedge clk);
        total++;
        if (gnt_m !== 8'h04) begin
            bad++;
            $display("FAIL skip_g2: gnt=%h want 04", gnt_m);
        end
        req_m = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_hold_limit();
        req_h = 8'h03;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            total++;
            if (gnt_0 !== 8'h01 || to_0 !== 1'b0) begin
                bad++;
                $display("FAIL nolimit_c%0d: gnt=%h timeout=%b want 01/0", i, gnt_0, to_0);
            end
            if (i <= 4) begin
                total++;
                if (gnt_4 !== 8'h01 || to_4 !== 1'b0) begin
                    bad++;
                    $display("FAIL hold_c%0d: gnt=%h timeout=%b want 01/0", i, gnt_4, to_4);
                end
            end else if (i == 5) begin
                total++;
                if (gnt_4 !== 8'h00 || gv_4 !== 1'b0 || to_4 !== 1'b1) begin
                    bad++;
                    $display("FAIL hold_timeout: gnt=%h valid=%b timeout=%b want 00/0/1", gnt_4, gv_4, to_4);
                end
            end else if (i == 6) begin
                total++;
                if (gnt_4 !== 8'h02 || to_4 !== 1'b0) begin
                    bad++;
                    $display("FAIL hold_next: gnt=%h timeout=%b want 02/0", gnt_4, to_4);
                end
            end
        end
        req_h = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        req_m = 8'h04;
        @(negedge clk);
        total++;
        if (gnt_m !== 8'h04) begin
            bad++;
            $display("FAIL simul_g2: gnt=%h want 04", gnt_m);
        end
        req_m = 8'h20;
        @(negedge clk);
        total++;
        if (gnt_m !== 8'h00) begin
            bad++;
            $display("FAIL simul_bubble: gnt=%h want 00", gnt_m);
        end
        @(negedge clk);
        total++;
        if (gnt_m !== 8'h20) begin
            bad++;
            $display("FAIL simul_g5: gnt=%h want 20", gnt_m);
        end
        req_m = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 2000; c++) begin
            req_m = 8'($urandom);
            req_h = 8'($urandom);
            rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            @(negedge clk);
            total++;
            if ($countones(gnt_m) > 1 || gv_m !== (|gnt_m) || (to_m && gnt_m != 8'h00) ||
                (gnt_m != 8'h00 && (8'h01 << enc(gnt_m)) !== gnt_m) ||
                $countones(gnt_4) > 1 || gv_4 !== (|gnt_4) || (to_4 && gnt_4 != 8'h00) ||
                (gnt_4 != 8'h00 && (8'h01 << enc(gnt_4)) !== gnt_4)) begin
                bad++;
                if (errs < 10)
                    $display("FAIL invariant_c%0d: gnt=%h valid=%b timeout=%b gnt4=%h valid4=%b timeout4=%b want one-hot/valid==|gnt/no timeout with grant",
                             c, gnt_m, gv_m, to_m, gnt_4, gv_4, to_4);
                errs++;
            end
        end
        rst_n = 1'b1;
        req_m = 8'h00;
        req_h = 8'h00;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req_m = 8'h00;
        req_h = 8'h00;
        test_reset();
        test_round_robin();
        test_skip_wrap();
        test_hold_limit();
        test_simultaneous();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
